// File: rtl/ov7670_dvp_emulator.sv
// OV7670 DVP (RGB565) emulator: generates VSYNC/HREF/D frame timing with
// selectable test patterns so the capture path can run without a sensor.
// Ports:
//   clk_24m      byte clock, also used as PCLK by the capture logic
//   rst_24m      asynchronous active-high reset
//   enable       run frames while high; a running frame always completes
//   pattern_sel  0 colour bars, 1 coordinate, 2 frame fill, 3 checkerboard
//   cam_VSYNC    frame sync, active high
//   cam_HREF     high during active bytes of a line
//   cam_D        pixel byte, low byte of each pixel first
//   frame_count  completed frames (wraps)
//   frame_done   one-cycle pulse at the end of each frame
module ov7670_dvp_emulator #(
  parameter int unsigned FRAME_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT  = 480,
  parameter int unsigned H_BLANK       = 144,
  parameter int unsigned VSYNC_LINES   = 3,
  parameter int unsigned V_BACK_LINES  = 17,
  parameter int unsigned V_FRONT_LINES = 10
) (
  input  logic        clk_24m,
  input  logic        rst_24m,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_VSYNC,
  output logic        cam_HREF,
  output logic [7:0]  cam_D,
  output logic [15:0] frame_count,
  output logic        frame_done
);

  localparam int unsigned ACT_BYTES = 2 * FRAME_WIDTH;
  localparam int unsigned LINE_LEN  = ACT_BYTES + H_BLANK;
  localparam int unsigned H_W       = $clog2(LINE_LEN);
  localparam int unsigned MAX_A     = (FRAME_HEIGHT > VSYNC_LINES) ? FRAME_HEIGHT : VSYNC_LINES;
  localparam int unsigned MAX_B     = (V_BACK_LINES > V_FRONT_LINES) ? V_BACK_LINES : V_FRONT_LINES;
  localparam int unsigned MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned L_W       = $clog2(MAX_LINES + 1);
  localparam int unsigned BAR_W     = FRAME_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  state_e         state_q, state_d;
  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [L_W-1:0] line_cnt_q, line_cnt_d;
  logic [1:0]     pattern_q, pattern_d;
  logic [15:0]    fill_q, fill_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic           frame_done_q, frame_done_d;
  logic           vsync_q, vsync_d;
  logic           href_q, href_d;
  logic [7:0]     data_q, data_d;

  logic           line_end;
  logic [H_W-1:0] hx;
  logic [7:0]     x8, y8;
  logic [2:0]     bar;
  logic [15:0]    pix;
  logic [7:0]     pix_byte;

  assign line_end = (h_cnt_q == H_W'(LINE_LEN - 1));

  // Pixel coordinates: two byte clocks per pixel; y is the active line index.
  assign hx  = h_cnt_q >> 1;
  assign x8  = 8'(hx);
  assign y8  = 8'(line_cnt_q);
  assign bar = 3'(hx / H_W'(BAR_W));

  // Test pattern pixel for the current position.
  always_comb begin
    pix = 16'h0000;
    case (pattern_q)
      2'd0: begin
        case (bar)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = {y8, x8};
      2'd2:    pix = fill_q;
      default: pix = (x8[3] ^ y8[3]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  // Low byte on even byte clocks, high byte on odd.
  assign pix_byte = h_cnt_q[0] ? pix[15:8] : pix[7:0];

  // Frame sequencer and registered output values.
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    line_cnt_d    = line_cnt_q;
    pattern_d     = pattern_q;
    fill_d        = fill_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    vsync_d       = 1'b0;
    href_d        = 1'b0;
    data_d        = 8'h00;

    if (state_q != ST_IDLE) begin
      h_cnt_d = line_end ? '0 : h_cnt_q + H_W'(1);
      if (line_end) line_cnt_d = line_cnt_q + L_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        h_cnt_d    = '0;
        line_cnt_d = '0;
        if (enable) begin
          state_d   = ST_VSYNC;
          pattern_d = pattern_sel;
          fill_d    = frame_count_q;
        end
      end
      ST_VSYNC: begin
        vsync_d = 1'b1;
        if (line_end && line_cnt_q == L_W'(VSYNC_LINES - 1)) begin
          line_cnt_d = '0;
          state_d    = (V_BACK_LINES == 0) ? ST_ACTIVE : ST_VBACK;
        end
      end
      ST_VBACK: begin
        if (line_end && line_cnt_q == L_W'(V_BACK_LINES - 1)) begin
          line_cnt_d = '0;
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        href_d = (h_cnt_q < H_W'(ACT_BYTES));
        data_d = href_d ? pix_byte : 8'h00;
        if (line_end && line_cnt_q == L_W'(FRAME_HEIGHT - 1)) begin
          line_cnt_d = '0;
          state_d    = ST_VFRONT;
        end
      end
      ST_VFRONT: begin
        if (line_end && line_cnt_q == L_W'(V_FRONT_LINES - 1)) begin
          line_cnt_d    = '0;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          if (enable) begin
            state_d   = ST_VSYNC;
            pattern_d = pattern_sel;
            fill_d    = frame_count_d;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_24m or posedge rst_24m) begin
    if (rst_24m) begin
      state_q       <= ST_IDLE;
      h_cnt_q       <= '0;
      line_cnt_q    <= '0;
      pattern_q     <= 2'd0;
      fill_q        <= 16'h0000;
      frame_count_q <= 16'h0000;
      frame_done_q  <= 1'b0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      line_cnt_q    <= line_cnt_d;
      pattern_q     <= pattern_d;
      fill_q        <= fill_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data_q        <= data_d;
    end
  end

  assign cam_VSYNC   = vsync_q;
  assign cam_HREF    = href_q;
  assign cam_D       = data_q;
  assign frame_count = frame_count_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
// Self-checking bench for ov7670_dvp_emulator with a small frame geometry.
// Expected outputs come from a frame-offset model: given the cycle index t
// within a frame (t=0 is the first VSYNC-high cycle), the pattern latched for
// that frame and the frame-start count, it derives VSYNC/HREF/D/frame_done.
module tb_ov7670_dvp_emulator;

  localparam int FW = 8;
  localparam int FH = 4;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int LL = 2 * FW + HB;
  localparam int FL = (VS + VB + FH + VF) * LL;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        cam_VSYNC;
  logic        cam_HREF;
  logic [7:0]  cam_D;
  logic [15:0] frame_count;
  logic        frame_done;

  int          checks;
  int          errors;
  logic [15:0] exp_count;
  int          cur_pat;

  ov7670_dvp_emulator #(
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .H_BLANK      (HB),
    .VSYNC_LINES  (VS),
    .V_BACK_LINES (VB),
    .V_FRONT_LINES(VF)
  ) dut (
    .clk_24m    (clk),
    .rst_24m    (rst),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .cam_VSYNC  (cam_VSYNC),
    .cam_HREF   (cam_HREF),
    .cam_D      (cam_D),
    .frame_count(frame_count),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] bar_colour(input int b);
    case (b)
      0:       return 16'hFFFF;
      1:       return 16'hFFE0;
      2:       return 16'h07FF;
      3:       return 16'h07E0;
      4:       return 16'hF81F;
      5:       return 16'hF800;
      6:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // {vsync, href, d[7:0], done} expected at frame offset t.
  function automatic logic [10:0] exp_out(input int t, input int pat, input logic [15:0] fill);
    int          line;
    int          col;
    int          y;
    int          x;
    bit          act;
    logic [15:0] pix;
    logic [7:0]  d;
    line = t / LL;
    col  = t % LL;
    y    = line - (VS + VB);
    x    = col / 2;
    act  = (y >= 0) && (y < FH) && (col < 2 * FW);
    case (pat)
      0:       pix = bar_colour(x / (FW / 8));
      1:       pix = {8'(y), 8'(x)};
      2:       pix = fill;
      default: pix = (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 16'hFFFF : 16'h0000;
    endcase
    d = act ? ((col % 2) == 1 ? pix[15:8] : pix[7:0]) : 8'h00;
    return {(line < VS), act, d, (t == FL - 1)};
  endfunction

  // Returns negedges until VSYNC is seen high (bounded).
  task automatic wait_vsync(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (cam_VSYNC !== 1'b1 && cycles < 400);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    exp_count = 16'h0000;
    @(negedge clk);
    checks++;
    if ({cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state got %h required 0", {cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count} !== 27'd0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d got %h required 0", i, {cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count});
      end
    end
  endtask

  task automatic test_frame_timing();
    int          cyc;
    logic [10:0] got;
    logic [10:0] e;
    logic [15:0] fill;
    pattern_sel = 2'd1;
    enable = 1'b1;
    wait_vsync(cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL start_latency got %0d required 2", cyc);
    end
    for (int f = 0; f < 2; f++) begin
      fill = exp_count;
      for (int t = 0; t < FL; t++) begin
        e = exp_out(t, 1, fill);
        got = {cam_VSYNC, cam_HREF, cam_D, frame_done};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL timing f%0d t%0d got %h required %h", f, t, got, e);
        end
        if (t == FL - 1) begin
          exp_count++;
          checks++;
          if (frame_count !== exp_count) begin
            errors++;
            $display("FAIL timing_count f%0d got %h required %h", f, frame_count, exp_count);
          end
        end
        @(negedge clk);
      end
    end
    checks++;
    if (cam_VSYNC !== 1'b1) begin
      errors++;
      $display("FAIL next_vsync got %b required 1", cam_VSYNC);
    end
    cur_pat = 1;
  endtask

  task automatic test_pattern_latch();
    int          pats[3];
    logic [10:0] got;
    logic [10:0] e;
    logic [15:0] fill;
    pats[0] = cur_pat;
    pats[1] = 0;
    pats[2] = 3;
    pattern_sel = 2'd0;
    for (int f = 0; f < 3; f++) begin
      fill = exp_count;
      for (int t = 0; t < FL; t++) begin
        e = exp_out(t, pats[f], fill);
        got = {cam_VSYNC, cam_HREF, cam_D, frame_done};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL latch f%0d pat%0d t%0d got %h required %h", f, pats[f], t, got, e);
        end
        if (t == FL - 1) begin
          exp_count++;
          checks++;
          if (frame_count !== exp_count) begin
            errors++;
            $display("FAIL latch_count f%0d got %h required %h", f, frame_count, exp_count);
          end
        end
        if (f == 1 && t == 60) pattern_sel = 2'd3;
        @(negedge clk);
      end
    end
    cur_pat = 3;
  endtask

  task automatic test_random_frames();
    int          cur;
    int          nxt;
    logic [10:0] got;
    logic [10:0] e;
    logic [15:0] fill;
    cur = cur_pat;
    for (int f = 0; f < 4; f++) begin
      fill = exp_count;
      nxt = cur;
      for (int t = 0; t < FL; t++) begin
        e = exp_out(t, cur, fill);
        got = {cam_VSYNC, cam_HREF, cam_D, frame_done};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL random f%0d pat%0d t%0d got %h required %h", f, cur, t, got, e);
        end
        if (t == FL - 1) begin
          nxt = int'(pattern_sel);
          exp_count++;
          checks++;
          if (frame_count !== exp_count) begin
            errors++;
            $display("FAIL random_count f%0d got %h required %h", f, frame_count, exp_count);
          end
        end else if (t <= 130 && $urandom_range(0, 15) == 0) begin
          pattern_sel = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
      end
      cur = nxt;
    end
    cur_pat = cur;
  endtask

  task automatic test_enable_drop();
    int          pats[2];
    logic [10:0] got;
    logic [10:0] e;
    logic [15:0] fill;
    pats[0] = cur_pat;
    pats[1] = 2;
    pattern_sel = 2'd2;
    for (int f = 0; f < 2; f++) begin
      fill = exp_count;
      for (int t = 0; t < FL; t++) begin
        e = exp_out(t, pats[f], fill);
        got = {cam_VSYNC, cam_HREF, cam_D, frame_done};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL drop f%0d t%0d got %h required %h", f, t, got, e);
        end
        if (t == FL - 1) exp_count++;
        if (f == 1 && t == 70) enable = 1'b0;
        @(negedge clk);
      end
    end
    for (int i = 0; i < 200; i++) begin
      checks++;
      if ({cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count} !== {11'd0, exp_count}) begin
        errors++;
        $display("FAIL drop_idle cycle %0d got %h required %h", i,
                 {cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count}, {11'd0, exp_count});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    int          cyc;
    logic [10:0] got;
    logic [10:0] e;
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    exp_count = 16'hFFFF;
    checks++;
    if (frame_count !== exp_count) begin
      errors++;
      $display("FAIL wrap_preset got %h required %h", frame_count, exp_count);
    end
    pattern_sel = 2'd2;
    enable = 1'b1;
    wait_vsync(cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL wrap_latency got %0d required 2", cyc);
    end
    for (int t = 0; t < FL; t++) begin
      e = exp_out(t, 2, 16'hFFFF);
      got = {cam_VSYNC, cam_HREF, cam_D, frame_done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wrap_fill t%0d got %h required %h", t, got, e);
      end
      if (t == FL - 1) begin
        exp_count++;
        checks++;
        if (frame_count !== exp_count) begin
          errors++;
          $display("FAIL wrap_count got %h required %h", frame_count, exp_count);
        end
      end
      if (t == 10) enable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    int          cyc;
    logic [10:0] got;
    logic [10:0] e;
    pattern_sel = 2'd0;
    enable = 1'b1;
    wait_vsync(cyc);
    checks++;
    if (cyc < 2 || cyc > 3) begin
      errors++;
      $display("FAIL areset_latency got %0d required 2..3", cyc);
    end
    for (int t = 0; t < 72; t++) begin
      e = exp_out(t, 0, exp_count);
      got = {cam_VSYNC, cam_HREF, cam_D, frame_done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL bars t%0d got %h required %h", t, got, e);
      end
      if (t < 71) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset got %h required 0", {cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count});
    end
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count} !== 27'd0) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d got %h required 0", i,
                 {cam_VSYNC, cam_HREF, cam_D, frame_done, frame_count});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cur_pat = 0;
    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    exp_count = 16'h0000;
    test_reset();
    test_frame_timing();
    test_pattern_latch();
    test_random_frames();
    test_enable_drop();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_dvp_emulator.md
Name: ov7670_dvp_emulator

Overview:
- Synthesizable stand-in for the OV7670 sensor's parallel pixel output (DVP) in RGB565 mode.
- Drives cam_VSYNC, cam_HREF and cam_D with selectable test patterns. The camera capture path and rgb2ycbcr chain can then be simulated and brought up on the board without a sensor.
- Sits where the physical camera would sit. Its clock doubles as cam_PCLK for the capture logic.

Parameters:
- FRAME_WIDTH, 640, active pixels per line (even, multiple of 8)
- FRAME_HEIGHT, 480, active lines per frame
- H_BLANK, 144, byte clocks with HREF low at end of every line (>=1)
- VSYNC_LINES, 3, lines with VSYNC high at frame start (>=1)
- V_BACK_LINES, 17, blank lines after VSYNC before first active line (>=0)
- V_FRONT_LINES, 10, blank lines after last active line (>=1)

Ports:
- clk_24m, input, 1, byte clock; also forwarded as PCLK to the capture logic
- rst_24m, input, 1, reset, asynchronous, active-high
- enable, input, 1, run frames while high
- pattern_sel, input, 2, 0 colour bars, 1 coordinate, 2 frame fill, 3 checkerboard
- cam_VSYNC, output, 1, frame sync, active high
- cam_HREF, output, 1, high during active bytes of a line
- cam_D, output, 8, pixel byte
- frame_count, output, 16, completed frames
- frame_done, output, 1, one-cycle pulse at end of each frame

Behaviour:
- Clocking and reset: one clock domain, clk_24m. Reset is asynchronous and active-high (rst_24m).
- Reset state: state=IDLE; all counters 0. cam_VSYNC=0, cam_HREF=0, cam_D=8'h00, frame_count=0, frame_done=0.
- Output timing: all outputs are registered and change only on posedge clk_24m. Latency from internal h_cnt/line state to outputs is 1 cycle.
- Line timing: LINE_LEN = 2*FRAME_WIDTH + H_BLANK byte clocks. h_cnt runs 0..LINE_LEN-1 and wraps; line_cnt advances on wrap.
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE: outputs low. If enable=1, go to VSYNC next cycle with h_cnt=0.
  - VSYNC: VSYNC_LINES lines. cam_VSYNC=1, HREF=0.
  - VBACK: V_BACK_LINES lines, all outputs low. Skipped when the count is 0.
  - ACTIVE: FRAME_HEIGHT lines. HREF=1 when h_cnt < 2*FRAME_WIDTH.
  - VFRONT: V_FRONT_LINES lines, outputs low.
- End of VFRONT: on the last cycle, pulse frame_done. frame_count increments and wraps 16'hFFFF to 0.
  - If enable=1, next state is VSYNC; otherwise IDLE.
- Enable deassert mid-frame: the current frame always completes; the block stops only at the frame boundary.
- Pattern latch: pattern_sel is latched on entry to VSYNC and is stable for the whole frame.
- Pixel addressing: x = h_cnt>>1, y = active line index.
  - Byte order is little-endian, matching capture (even byte count into [7:0]).
  - h_cnt[0]=0 drives pix[7:0]; h_cnt[0]=1 drives pix[15:8].
- Patterns (16-bit RGB565 pix):
  - 0: eight bars, each FRAME_WIDTH/8 wide, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1: pix = {y[7:0], x[7:0]}.
  - 2: pix = frame_count value at frame start.
  - 3: pix = (x[3]^y[3]) ? 16'hFFFF : 16'h0000.
- cam_D is 8'h00 whenever HREF is low.
- Width rules: h_cnt and line_cnt are sized with $clog2 of their max+1. x and y are truncated for patterns 1/3; no overflow is possible in the counters.

Test Plan:
Small parameters for all scenarios: FRAME_WIDTH=8, FRAME_HEIGHT=4, H_BLANK=4, VSYNC_LINES=1, V_BACK_LINES=1, V_FRONT_LINES=1. This gives LINE_LEN=20 and 140 cycles per frame.
- Reset and idle: assert rst_24m mid-frame with enable=1 → all outputs 0 asynchronously. After release with enable=0 → outputs stay 0 indefinitely.
- Frame timing: enable=1, pattern 1 → VSYNC high for 20 cycles, then 20 low. Then 4 lines, each with 16 HREF-high cycles followed by 4 low. Then 20 low, frame_done one cycle, frame_count=1, next VSYNC immediately.
- Coordinate bytes: pattern 1, line y=2 → cam_D sequence 00,02,01,02,02,02,…,07,02 during HREF.
- Colour bars: pattern 0 → per line cam_D = FF,FF,E0,FF,FF,07,E0,07,1F,F8,00,F8,1F,00,00,00.
- Pattern latch: change pattern_sel 0→3 during ACTIVE of frame 0 → frame 0 is still bars. Frame 1 is checkerboard: all 16'h0000, since x<8 and y<8 make x[3]^y[3]=0.
- Enable drop and wrap: deassert enable mid-ACTIVE → frame completes, frame_done pulses, state goes IDLE, no further VSYNC. Force frame_count=16'hFFFF → after the next frame it reads 0, and pattern 2 fills that frame with bytes FF,FF.
